lr35902_brom_loader: RTL

- Writer side of the boot ROM: after reset, fetches the 256-byte boot image from external SPI flash and writes it into the boot RAM write port.
- Holds the LR35902 core in reset until the image is complete.
- Sits between the board SPI flash pins and the boot RAM (256x8) read by the CPU at 0x0000-0x00FF.

---
 rtl/lr35902_brom_loader_pkg.sv | 27 ++
 rtl/lr35902_spi_shift.sv | 93 +++++++++
 rtl/lr35902_brom_loader.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/lr35902_brom_loader_pkg.sv
// Shared constants, FSM state encoding and flash command helper for the boot ROM loader.
// Pure definitions; no timing or flow control lives here.
package lr35902_brom_loader_pkg;

    localparam logic [7:0] SPI_CMD_READ = 8'h03;
    localparam int         BROM_LEN     = 256;

    typedef enum logic [2:0] {
        ST_GAP   = 3'd0,
        ST_CMD   = 3'd1,
        ST_DATA  = 3'd2,
        ST_END   = 3'd3,
        ST_DONE  = 3'd4,
        ST_ERROR = 3'd5
    } state_e;

    // Command phase byte sequence: opcode, then the 24-bit address MSB first.
    function automatic logic [7:0] cmd_byte(input logic [23:0] adr, input logic [1:0] idx);
        case (idx)
            2'd0:    cmd_byte = SPI_CMD_READ;
            2'd1:    cmd_byte = adr[23:16];
            2'd2:    cmd_byte = adr[15:8];
            default: cmd_byte = adr[7:0];
        endcase
    endfunction

endpackage

// File: rtl/lr35902_spi_shift.sv
// SPI mode-0 byte engine: SCK divider plus 8-bit shifter, streams back-to-back bytes while go_i stays high.
// byte_done_o strobes in the cycle whose clk edge raises SCK for bit 7; rx_byte_o is the complete byte then.
module lr35902_spi_shift #(
    parameter int CLK_DIV = 2
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       go_i,
    input  logic [7:0] tx_byte_i,
    input  logic       spi_miso_i,
    output logic [7:0] rx_byte_o,
    output logic       byte_done_o,
    output logic       active_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o
);

    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    logic       active_q, active_d;
    logic       sck_q, sck_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] rx_q, rx_d;
    logic       tick;

    assign tick        = active_q && (cnt_q == DIV_LAST);
    assign byte_done_o = tick && !sck_q && (bit_q == 3'd7);
    assign rx_byte_o   = {rx_q[6:0], spi_miso_i};
    assign active_o    = active_q;
    assign spi_sck_o   = sck_q;
    assign spi_mosi_o  = tx_q[7];

    always_comb begin
        active_d = active_q;
        sck_d    = sck_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        rx_d     = rx_q;
        if (!active_q) begin
            if (go_i) begin
                active_d = 1'b1;
                tx_d     = tx_byte_i;
                cnt_d    = 8'd0;
                bit_d    = 3'd0;
            end
        end else if (tick) begin
            cnt_d = 8'd0;
            if (!sck_q) begin
                sck_d = 1'b1;
                rx_d  = rx_byte_o;
            end else begin
                // Falling edge: the only moment MOSI moves, so it is stable across every rising edge.
                sck_d = 1'b0;
                if (bit_q == 3'd7) begin
                    bit_d = 3'd0;
                    if (go_i) begin
                        tx_d = tx_byte_i;
                    end else begin
                        active_d = 1'b0;
                        tx_d     = 8'd0;
                    end
                end else begin
                    bit_d = bit_q + 3'd1;
                    tx_d  = {tx_q[6:0], 1'b0};
                end
            end
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            cnt_q    <= 8'd0;
            bit_q    <= 3'd0;
            tx_q     <= 8'd0;
            rx_q     <= 8'd0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            rx_q     <= rx_d;
        end
    end

endmodule

// File: rtl/lr35902_brom_loader.sv
// Boot ROM loader: reads the boot image from SPI flash (cmd 03h) into boot RAM, holding the CPU until done; one wr_en per byte.
// `LR35902_BLOAD_CHECKSUM_EN adds a 257th checksum byte (sum of all 257 == 0) and the ERROR outcome.
module lr35902_brom_loader
    import lr35902_brom_loader_pkg::*;
#(
    parameter int          CLK_DIV   = 2,
    parameter logic [23:0] FLASH_ADR = 24'h000000,
    parameter int          CS_GAP    = 4
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    output logic       spi_cs_n_o,
    output logic       spi_sck_o,
    output logic       spi_mosi_o,
    input  logic       spi_miso_i,
    output logic [7:0] wr_adr_o,
    output logic [7:0] wr_data_o,
    output logic       wr_en_o,
    output logic       busy_o,
    output logic       cpu_hold_o,
    output logic       error_o
);

    localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
`ifdef LR35902_BLOAD_CHECKSUM_EN
    localparam logic [8:0] LAST_IDX = 9'(BROM_LEN);
`else
    localparam logic [8:0] LAST_IDX = 9'(BROM_LEN - 1);
`endif

    state_e     state_q;
    logic [7:0] gap_cnt_q;
    logic [1:0] cmd_idx_q;
    logic [8:0] byte_idx_q;
    logic       go_q;
    logic [7:0] tx_q;
    logic       cs_n_q;
    logic       wr_en_q;
    logic [7:0] wr_adr_q;
    logic [7:0] wr_data_q;
    logic       busy_q;
    logic       hold_q;

    logic       byte_done;
    logic [7:0] rx_byte;
    logic       shift_active;

`ifdef LR35902_BLOAD_CHECKSUM_EN
    logic [7:0] sum_q;
    logic [7:0] sum_nxt;
    logic       err_q;
    assign sum_nxt = sum_q + rx_byte;
    assign error_o = err_q;
`else
    assign error_o = 1'b0;
`endif

    assign spi_cs_n_o = cs_n_q;
    assign wr_adr_o   = wr_adr_q;
    assign wr_data_o  = wr_data_q;
    assign wr_en_o    = wr_en_q;
    assign busy_o     = busy_q;
    assign cpu_hold_o = hold_q;

    lr35902_spi_shift #(
        .CLK_DIV (CLK_DIV)
    ) u_shift (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .go_i        (go_q),
        .tx_byte_i   (tx_q),
        .spi_miso_i  (spi_miso_i),
        .rx_byte_o   (rx_byte),
        .byte_done_o (byte_done),
        .active_o    (shift_active),
        .spi_sck_o   (spi_sck_o),
        .spi_mosi_o  (spi_mosi_o)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_GAP;
            gap_cnt_q  <= 8'd0;
            cmd_idx_q  <= 2'd0;
            byte_idx_q <= 9'd0;
            go_q       <= 1'b0;
            tx_q       <= 8'd0;
            cs_n_q     <= 1'b1;
            wr_en_q    <= 1'b0;
            wr_adr_q   <= 8'd0;
            wr_data_q  <= 8'd0;
            busy_q     <= 1'b1;
            hold_q     <= 1'b1;
`ifdef LR35902_BLOAD_CHECKSUM_EN
            sum_q      <= 8'd0;
            err_q      <= 1'b0;
`endif
        end else begin
            wr_en_q <= 1'b0;
            // Address advances after each write strobe and naturally wraps 0xFF -> 0x00.
            if (wr_en_q) begin
                wr_adr_q <= wr_adr_q + 8'd1;
            end
            case (state_q)
                ST_GAP: begin
                    if (gap_cnt_q == GAP_LAST) begin
                        gap_cnt_q  <= 8'd0;
                        state_q    <= ST_CMD;
                        cs_n_q     <= 1'b0;
                        go_q       <= 1'b1;
                        tx_q       <= cmd_byte(FLASH_ADR, 2'd0);
                        cmd_idx_q  <= 2'd0;
                        byte_idx_q <= 9'd0;
`ifdef LR35902_BLOAD_CHECKSUM_EN
                        sum_q      <= 8'd0;
`endif
                    end else begin
                        gap_cnt_q <= gap_cnt_q + 8'd1;
                    end
                end
                ST_CMD: begin
                    if (byte_done) begin
                        cmd_idx_q <= cmd_idx_q + 2'd1;
                        if (cmd_idx_q == 2'd3) begin
                            state_q <= ST_DATA;
                            tx_q    <= 8'd0;
                        end else begin
                            tx_q <= cmd_byte(FLASH_ADR, cmd_idx_q + 2'd1);
                        end
                    end
                end
                ST_DATA: begin
                    if (byte_done) begin
                        byte_idx_q <= byte_idx_q + 9'd1;
`ifdef LR35902_BLOAD_CHECKSUM_EN
                        sum_q <= sum_nxt;
                        if (byte_idx_q != LAST_IDX) begin
                            wr_en_q   <= 1'b1;
                            wr_data_q <= rx_byte;
                        end
`else
                        wr_en_q   <= 1'b1;
                        wr_data_q <= rx_byte;
`endif
                        if (byte_idx_q == LAST_IDX) begin
                            go_q    <= 1'b0;
                            state_q <= ST_END;
                        end
                    end
                end
                ST_END: begin
                    // Release CS only once the shifter has dropped SCK after its final high phase.
                    if (!shift_active) begin
                        if (!cs_n_q) begin
                            cs_n_q    <= 1'b1;
                            gap_cnt_q <= 8'd0;
                        end else if (gap_cnt_q == GAP_LAST) begin
                            gap_cnt_q <= 8'd0;
                            busy_q    <= 1'b0;
`ifdef LR35902_BLOAD_CHECKSUM_EN
                            if (sum_q == 8'd0) begin
                                state_q <= ST_DONE;
                                hold_q  <= 1'b0;
                            end else begin
                                state_q <= ST_ERROR;
                                err_q   <= 1'b1;
                            end
`else
                            state_q <= ST_DONE;
                            hold_q  <= 1'b0;
`endif
                        end else begin
                            gap_cnt_q <= gap_cnt_q + 8'd1;
                        end
                    end
                end
                ST_DONE, ST_ERROR: begin
                    if (start_i) begin
                        state_q   <= ST_GAP;
                        gap_cnt_q <= 8'd0;
                        busy_q    <= 1'b1;
                        hold_q    <= 1'b1;
`ifdef LR35902_BLOAD_CHECKSUM_EN
                        err_q     <= 1'b0;
`endif
                    end
                end
                default: begin
                    state_q <= ST_GAP;
                end
            endcase
        end
    end

endmodule
